// File: rtl/pdm_decimator.sv
// PDM microphone front end: generates micClk, samples the 1-bit stream and
// decimates it through a 3rd-order CIC into signed PCM with a valid pulse.
module pdm_decimator #(
   parameter int HALF_PER   = 25,
   parameter int DECIM_LOG2 = 6,
   parameter int OUT_W      = 16
) (
   input  logic                    clk,
   input  logic                    reset_L,
   input  logic                    enable,
   input  logic                    micData,
   output logic                    micClk,
   output logic                    sample_valid,
   output logic signed [OUT_W-1:0] sample,
   output logic                    running
);
   localparam int ACC_W = 3*DECIM_LOG2 + 2;
   localparam int SHIFT = 3*DECIM_LOG2 - (OUT_W - 1);
   localparam int DIV_W = $clog2(HALF_PER + 1);
   localparam logic [DIV_W-1:0]        DIV_LAST = DIV_W'(HALF_PER - 1);
   localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2**(OUT_W-1)) - 1);
   localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_WARMUP = 2'd1,
      S_RUN    = 2'd2
   } state_t;

   function automatic logic signed [OUT_W-1:0] scale_sat(input logic signed [ACC_W-1:0] v);
      logic signed [ACC_W-1:0] sh;
      sh = v >>> SHIFT;
      if (sh > SAT_MAX) begin
         scale_sat = SAT_MAX[OUT_W-1:0];
      end else if (sh < SAT_MIN) begin
         scale_sat = SAT_MIN[OUT_W-1:0];
      end else begin
         scale_sat = sh[OUT_W-1:0];
      end
   endfunction

   state_t                  state_q, state_d;
   logic                    mic_s1_q, mic_s2_q;
   logic [DIV_W-1:0]        div_q, div_d;
   logic                    mic_clk_q, mic_clk_d;
   logic [DECIM_LOG2-1:0]   bit_cnt_q, bit_cnt_d;
   logic [1:0]              wup_q, wup_d;
   logic signed [ACC_W-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
   logic signed [ACC_W-1:0] dl1_q, dl1_d, dl2_q, dl2_d, dl3_q, dl3_d;
   logic                    comb_pend_q, comb_pend_d, pres_pend_q, pres_pend_d;
   logic signed [OUT_W-1:0] sample_q, sample_d;
   logic                    valid_q, valid_d, running_q, running_d;

   logic                    active_s, tick_s, dec_s;
   logic signed [ACC_W-1:0] x_s, c1_s, c2_s, c3_s;

   assign active_s = (state_q != S_IDLE);
   // A bit is consumed on the last clk of the high phase, just before micClk falls.
   assign tick_s   = active_s && (div_q == DIV_LAST) && mic_clk_q;
   assign dec_s    = tick_s && (bit_cnt_q == {DECIM_LOG2{1'b1}});
   assign x_s      = mic_s2_q ? {{(ACC_W-1){1'b0}}, 1'b1} : {ACC_W{1'b1}};
   assign c1_s     = i3_q - dl1_q;
   assign c2_s     = c1_s - dl2_q;
   assign c3_s     = c2_s - dl3_q;

   assign micClk       = mic_clk_q;
   assign sample_valid = valid_q;
   assign sample       = sample_q;
   assign running      = running_q;

   // Capture FSM next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (enable) state_d = S_WARMUP;
            else        state_d = S_IDLE;
         end
         S_WARMUP: begin
            if (!enable)                        state_d = S_IDLE;
            else if (dec_s && (wup_q == 2'd2))  state_d = S_RUN;
            else                                state_d = S_WARMUP;
         end
         S_RUN: begin
            if (!enable) state_d = S_IDLE;
            else         state_d = S_RUN;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Divider, CIC integrators/combs and output register next values.
   always_comb begin
      div_d       = div_q;
      mic_clk_d   = mic_clk_q;
      bit_cnt_d   = bit_cnt_q;
      wup_d       = wup_q;
      i1_d        = i1_q;
      i2_d        = i2_q;
      i3_d        = i3_q;
      dl1_d       = dl1_q;
      dl2_d       = dl2_q;
      dl3_d       = dl3_q;
      comb_pend_d = 1'b0;
      pres_pend_d = 1'b0;
      sample_d    = sample_q;
      valid_d     = 1'b0;
      running_d   = (state_d == S_RUN);

      if (active_s && (div_q == DIV_LAST)) begin
         div_d     = '0;
         mic_clk_d = ~mic_clk_q;
      end else if (active_s) begin
         div_d = div_q + DIV_W'(1);
      end else begin
         div_d = div_q;
      end

      // Pipelined cascade: each stage accumulates its predecessor's old value.
      if (tick_s) begin
         i1_d      = i1_q + x_s;
         i2_d      = i2_q + i1_q;
         i3_d      = i3_q + i2_q;
         bit_cnt_d = bit_cnt_q + DECIM_LOG2'(1);
      end else begin
         bit_cnt_d = bit_cnt_q;
      end

      if (dec_s) begin
         comb_pend_d = 1'b1;
         pres_pend_d = (state_q == S_RUN);
         wup_d       = (state_q == S_WARMUP) ? (wup_q + 2'd1) : wup_q;
      end else begin
         comb_pend_d = 1'b0;
      end

      // Comb runs one clk after the event, still valid in the first IDLE clk.
      if (comb_pend_q) begin
         dl1_d   = i3_q;
         dl2_d   = c1_s;
         dl3_d   = c2_s;
         valid_d = pres_pend_q;
         if (pres_pend_q) sample_d = scale_sat(c3_s);
         else             sample_d = sample_q;
      end else begin
         valid_d = 1'b0;
      end

      if (state_d == S_IDLE) begin
         div_d     = '0;
         mic_clk_d = 1'b0;
      end else begin
         mic_clk_d = mic_clk_d;
      end

      if (state_q == S_IDLE) begin
         bit_cnt_d = '0;
         wup_d     = '0;
         i1_d      = '0;
         i2_d      = '0;
         i3_d      = '0;
         dl1_d     = '0;
         dl2_d     = '0;
         dl3_d     = '0;
      end else begin
         wup_d = wup_d;
      end
   end

   // micData synchroniser.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         mic_s1_q <= 1'b0;
         mic_s2_q <= 1'b0;
      end else begin
         mic_s1_q <= micData;
         mic_s2_q <= mic_s1_q;
      end
   end

   // State, datapath and output registers.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_q     <= S_IDLE;
         div_q       <= '0;
         mic_clk_q   <= 1'b0;
         bit_cnt_q   <= '0;
         wup_q       <= '0;
         i1_q        <= '0;
         i2_q        <= '0;
         i3_q        <= '0;
         dl1_q       <= '0;
         dl2_q       <= '0;
         dl3_q       <= '0;
         comb_pend_q <= 1'b0;
         pres_pend_q <= 1'b0;
         sample_q    <= '0;
         valid_q     <= 1'b0;
         running_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         div_q       <= div_d;
         mic_clk_q   <= mic_clk_d;
         bit_cnt_q   <= bit_cnt_d;
         wup_q       <= wup_d;
         i1_q        <= i1_d;
         i2_q        <= i2_d;
         i3_q        <= i3_d;
         dl1_q       <= dl1_d;
         dl2_q       <= dl2_d;
         dl3_q       <= dl3_d;
         comb_pend_q <= comb_pend_d;
         pres_pend_q <= pres_pend_d;
         sample_q    <= sample_d;
         valid_q     <= valid_d;
         running_q   <= running_d;
      end
   end
endmodule

// File: tb/tb_pdm_decimator.sv
// Self-checking bench for pdm_decimator: table-driven capture runs against a
// closed-form CIC reference, plus enable-drop, coincident-drop and reset sequences.
module tb_pdm_decimator;
   localparam int HP     = 25;
   localparam int R      = 64;
   localparam int FRAME  = R*2*HP;
   localparam int FIRST  = 4*FRAME + 1;
   localparam int RUN_AT = 3*FRAME;

   logic               clk = 1'b0;
   logic               reset_L;
   logic               enable;
   logic               micData;
   logic               micClk;
   logic               sample_valid;
   logic signed [15:0] sample;
   logic               running;

   pdm_decimator #(.HALF_PER(HP), .DECIM_LOG2(6), .OUT_W(16)) dut (
      .clk(clk), .reset_L(reset_L), .enable(enable), .micData(micData),
      .micClk(micClk), .sample_valid(sample_valid), .sample(sample), .running(running)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int   n_tests = 0;
   int   n_fail  = 0;
   int   bits[$];
   int   bit_idx = 0;
   logic prev_mc = 1'b0;
   logic prev_run = 1'b0;
   int   run_rise = -1;
   int   p_val[$];
   int   p_cyc[$];
   int   mc_edges[$];
   int   t0 = 0;

   typedef struct {
      string name;
      int    mode;      // 0 all ones, 1 all zeros, 2 alternating, 3 random
      int    dens;      // percent ones for random mode
      int    n_out;
      int    exp_val;
      bit    use_model;
   } vec_t;
   vec_t tbl[3];

   task automatic check(input string name, input longint act, input longint exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // One clk: observe outputs at negedge and advance the PDM bit after micClk falls.
   task automatic step();
      @(negedge clk);
      if (prev_mc && !micClk) begin
         bit_idx++;
         micData = (bit_idx < bits.size()) ? (bits[bit_idx] != 0) : 1'b0;
      end
      if (micClk != prev_mc) mc_edges.push_back(cyc);
      prev_mc = micClk;
      if (running && !prev_run) run_rise = cyc;
      prev_run = running;
      if (sample_valid) begin
         p_val.push_back(int'(sample));
         p_cyc.push_back(cyc);
      end
   endtask

   task automatic start_capture(input int mode, input int dens);
      bits.delete();
      for (int i = 0; i < 8*R; i++) begin
         case (mode)
            0:       bits.push_back(1);
            1:       bits.push_back(0);
            2:       bits.push_back((i % 2 == 0) ? 1 : 0);
            default: bits.push_back(($urandom_range(0, 99) < dens) ? 1 : 0);
         endcase
      end
      bit_idx = 0;
      micData = (bits[0] != 0);
      p_val.delete();
      p_cyc.delete();
      mc_edges.delete();
      run_rise = -1;
      enable = 1'b1;
      t0 = cyc + 1;
   endtask

   task automatic wait_pulses(input int n, input int budget);
      int c;
      c = 0;
      while (p_val.size() < n && c < budget) begin
         step();
         c++;
      end
      check("pulse_count", p_val.size(), n);
   endtask

   // Third integrator after n bits: sum of x[i] * C(n-1-i, 2).
   function automatic longint i3_at(input int n);
      longint acc, w;
      acc = 0;
      for (int i = 0; i <= n - 3; i++) begin
         w = (longint'(n - 1 - i) * longint'(n - 2 - i)) / 2;
         acc += (bits[i] != 0) ? w : -w;
      end
      return acc;
   endfunction

   // k-th decimated output (1-based): third difference with stride R, scaled and saturated.
   function automatic int model_out(input int k);
      longint y;
      y = i3_at(R*k) - 3*i3_at(R*(k-1)) + 3*i3_at(R*(k-2)) - i3_at(R*(k-3));
      y = y >>> 3;
      if (y > 32767)  y = 32767;
      if (y < -32768) y = -32768;
      return int'(y);
   endfunction

   initial begin
      int bad;
      int g;
      int n_before;

      tbl[0] = '{"all_ones",  0, 0,  2, 32767, 1'b0};
      tbl[1] = '{"alternate", 2, 0,  1, 0,     1'b0};
      tbl[2] = '{"random70",  3, 70, 1, 0,     1'b1};

      reset_L = 1'b1;
      enable  = 1'b0;
      micData = 1'b0;
      #2 reset_L = 1'b0;
      #1;
      check("rst_micClk", micClk, 0);
      check("rst_valid", sample_valid, 0);
      check("rst_sample", sample, 0);
      check("rst_running", running, 0);
      repeat (3) step();
      reset_L = 1'b1;

      bad = 0;
      repeat (1000) begin
         step();
         if (micClk || sample_valid || running || (sample != 16'sd0)) bad++;
      end
      check("idle_quiet_cycles", bad, 0);

      for (int i = 0; i < 3; i++) begin
         start_capture(tbl[i].mode, tbl[i].dens);
         wait_pulses(tbl[i].n_out, FIRST + tbl[i].n_out*FRAME + 50);
         if (p_cyc.size() > 0) check({tbl[i].name, "_first_latency"}, p_cyc[0] - t0, FIRST);
         for (int j = 0; j < p_val.size(); j++) begin
            check({tbl[i].name, "_sample"}, p_val[j],
                  tbl[i].use_model ? model_out(4 + j) : tbl[i].exp_val);
            if (j > 0) check({tbl[i].name, "_spacing"}, p_cyc[j] - p_cyc[j-1], FRAME);
         end
         if (i == 0) begin
            for (int k = 0; k < 4; k++) begin
               if (k < mc_edges.size()) check("micClk_edge_time", mc_edges[k] - t0, HP*(k+1));
               else check("micClk_edge_count", mc_edges.size(), 4);
            end
            check("running_rise_time", run_rise - t0, RUN_AT);
         end
         if (i < 2) begin
            enable = 1'b0;
            repeat (3) step();
         end
      end

      // Asynchronous reset in RUN, applied between clk edges while micClk is high.
      check("pre_reset_running", running, 1);
      g = 0;
      while (!micClk && g < 100) begin
         step();
         g++;
      end
      check("pre_reset_micClk", micClk, 1);
      #2 reset_L = 1'b0;
      #1;
      check("async_rst_sample", sample, 0);
      check("async_rst_micClk", micClk, 0);
      check("async_rst_running", running, 0);
      check("async_rst_valid", sample_valid, 0);
      enable = 1'b0;
      repeat (2) step();
      reset_L = 1'b1;
      bad = 0;
      repeat (200) begin
         step();
         if (micClk || running || sample_valid) bad++;
      end
      check("post_reset_idle", bad, 0);

      // All-zero capture, then enable dropped 1000 clk after a pulse.
      start_capture(1, 0);
      wait_pulses(1, FIRST + 50);
      if (p_val.size() > 0) check("all_zeros_sample", p_val[0], -32768);
      repeat (1000) step();
      enable = 1'b0;
      step();
      check("drop_running", running, 0);
      check("drop_micClk", micClk, 0);
      n_before = p_val.size();
      bad = 0;
      repeat (2500) begin
         step();
         if (micClk) bad++;
      end
      check("drop_no_pulse", p_val.size(), n_before);
      check("drop_micClk_idle", bad, 0);
      check("drop_sample_held", sample, -32768);

      // Re-enable: three outputs suppressed again, then drop enable on a decimation event.
      start_capture(3, 40);
      wait_pulses(1, FIRST + 50);
      if (p_cyc.size() > 0) check("reenable_latency", p_cyc[0] - t0, FIRST);
      if (p_val.size() > 0) check("reenable_sample", p_val[0], model_out(4));
      g = 0;
      while (cyc < t0 + 5*FRAME - 1 && g < FRAME + 100) begin
         step();
         g++;
      end
      enable = 1'b0;
      step();
      check("coincident_running", running, 0);
      wait_pulses(2, 10);
      if (p_cyc.size() > 1) check("coincident_pulse_time", p_cyc[1] - t0, 5*FRAME + 1);
      if (p_val.size() > 1) check("coincident_sample", p_val[1], model_out(5));
      bad = 0;
      repeat (200) begin
         step();
         if (micClk || running) bad++;
      end
      check("coincident_then_idle", bad, 0);
      check("coincident_no_extra", p_val.size(), 2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/pdm_decimator.md
Name: pdm_decimator

Overview:
- Front end of the voice path. Generates the PDM microphone clock and samples the 1-bit PDM stream.
- Converts the stream to 16-bit signed PCM using a 3rd-order CIC decimator.
- Presents one sample-valid pulse per output sample to the speech recogniser, which buffers and records the samples.
- Capture runs only while the record request is held.

Parameters:
- HALF_PER, 25: clk cycles per micClk half-period (100 MHz clk -> 2 MHz micClk).
- DECIM_LOG2, 6: log2 of the decimation ratio R (R=64 -> 31.25 kHz PCM).
- OUT_W, 16: PCM output width, signed.

Ports:
- clk, input, 1: system clock.
- reset_L, input, 1: reset, asynchronous, active-low.
- enable, input, 1: capture request (record button level).
- micData, input, 1: PDM data from the microphone. Asynchronous to clk.
- micClk, output, 1: PDM clock to the microphone.
- sample_valid, output, 1: one-cycle pulse; sample holds a new value.
- sample, output, OUT_W: signed PCM sample, held between pulses.
- running, output, 1: high in state RUN.

Behaviour:
- Clock and reset: one clock domain (clk). reset_L is asynchronous and active-low.
- Reset values:
  - micClk=0, sample_valid=0, sample=0, running=0, state=IDLE.
  - All counters and CIC registers are 0.
- Input synchronisation: micData passes through a 2-flop synchroniser before use (2 clk of latency, included in all timing below).
- FSM state IDLE:
  - micClk=0; divider, bit counter, warm-up counter and all integrators/combs held at 0.
  - enable=1 -> WARMUP on the next clk.
- FSM state WARMUP:
  - micClk and the CIC run.
  - The first 3 decimated outputs are discarded: sample_valid stays 0 and sample is unchanged.
  - After the 3rd output -> RUN.
- FSM state RUN: every decimated output is presented.
- Leaving WARMUP/RUN: enable=0 in WARMUP or RUN -> IDLE on the next clk. The partial accumulation is discarded and sample keeps its last value.
- Simultaneous events: enable falling in the same cycle as a decimation event -> the output is still presented (sample_valid=1 that cycle), then IDLE.
- micClk divider:
  - On entering WARMUP, div=0 and micClk=0.
  - div increments every clk. At div==HALF_PER-1: div<=0 and micClk toggles.
  - Period is 2*HALF_PER clk, 50% duty.
- Bit tick:
  - Occurs on the cycle with div==HALF_PER-1 and micClk==1, i.e. just before the falling edge.
  - The synchronised micData bit is taken on that cycle.
  - Bit mapping: 1 -> +1, 0 -> -1.
- CIC arithmetic:
  - Accumulator width ACC_W = 3*DECIM_LOG2+2 (20 at default), two's complement.
  - All integrators and combs wrap modulo 2^ACC_W; no overflow detection is needed.
  - On each bit tick: I1+=x, I2+=I1, I3+=I2. Each integrator uses the previous stage's pre-update value; this is a pipelined cascade.
  - A bit counter counts ticks 0..R-1. Decimation event = the tick where the count wraps from R-1 to 0.
- Comb stage:
  - Runs in the clk cycle after a decimation event, on the I3 value.
  - C1=I3-d1, C2=C1-d2, C3=C2-d3, with each delay register updated to its stage input.
- Output scaling:
  - Arithmetic shift right by 3*DECIM_LOG2-(OUT_W-1) (3 at default).
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Full-scale +1 input gives +32768 before saturation, output 32767.
- Output timing:
  - sample and sample_valid are registered.
  - Pulse appears 2 clk after the decimation event's bit tick, lasting exactly 1 clk.
  - Minimum spacing between pulses is R*2*HALF_PER clk (3200 at default).
- Reset mid-operation: asserting reset_L low at any time returns all outputs to their reset values immediately, without waiting for a clock.

Test Plan:
- Reset, enable=0, 1000 clk -> micClk=0, sample_valid=0, sample=0, running=0 throughout.
- enable=1 at cycle T, micData=1 constant:
  - micClk toggles every 25 clk.
  - First sample_valid follows the 256th bit tick, approx. T+12800+sync/pipe latency.
  - running goes high with the 3rd discarded output.
  - Every sample = 32767; pulse spacing = 3200 clk.
- micData=0 constant, enable held -> after warm-up every sample = -32768.
- micData alternating 1/0 on successive bit ticks -> after warm-up every sample = 0.
- enable dropped mid-frame 1000 clk after a pulse:
  - IDLE next clk; micClk=0; no further pulse.
  - sample holds its last value.
  - Re-enable -> 3 outputs suppressed again before the next pulse.
- reset_L asserted asynchronously (between clk edges) during RUN -> sample=0, micClk=0, running=0 before the next clk edge; after release, IDLE with enable required.
